pwl_chaos_rng: RTL

PWL_CHAOS_RNG -- requirements
Module: pwl_chaos_rng

---
 rtl/pwl_rng_pkg.sv | 20 ++
 rtl/pwl_divider.sv | 64 ++++++
 rtl/pwl_chaos_rng.sv | 122 ++++++++++++
 3 files changed

// File: rtl/pwl_rng_pkg.sv
// Shared encodings and default constants for the piecewise-linear chaotic RNG.
package pwl_rng_pkg;

   typedef enum logic [1:0] {
      ModeSkew    = 2'b00,
      ModeTent    = 2'b01,
      ModeShift   = 2'b10,
      ModeSkewAlt = 2'b11
   } mode_e;

   typedef enum logic [1:0] {
      StIdle = 2'b00,
      StCalc = 2'b01,
      StDone = 2'b10
   } state_e;

   localparam logic [15:0] DefaultSeed    = 16'hACE1;
   localparam logic [15:0] DefaultPerturb = 16'h9E37;

endpackage

// File: rtl/pwl_divider.sv
// Restoring divider, one quotient bit per cycle.
// quotient = floor(dividend * 2^WIDTH / divisor); requires dividend < divisor.
module pwl_divider #(
   parameter int unsigned WIDTH = 16
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             done,
   output logic [WIDTH-1:0] quotient
);

   localparam int unsigned CntW = $clog2(WIDTH + 1);

   logic [WIDTH-1:0] rem_q, rem_d;
   logic [WIDTH-1:0] dsr_q, dsr_d;
   logic [WIDTH-2:0] quo_q, quo_d;
   logic [CntW-1:0]  cnt_q, cnt_d;
   logic [WIDTH:0]   trial;
   logic [WIDTH:0]   diff;
   logic             fits;

   always_comb begin
      trial = {rem_q, 1'b0};
      diff  = trial - {1'b0, dsr_q};
      fits  = (trial >= {1'b0, dsr_q});
      rem_d = rem_q;
      dsr_d = dsr_q;
      quo_d = quo_q;
      cnt_d = cnt_q;
      if (start) begin
         rem_d = dividend;
         dsr_d = divisor;
         quo_d = '0;
         cnt_d = CntW'(WIDTH);
      end else if (cnt_q != '0) begin
         // Remainder stays below the divisor, so it always fits in WIDTH bits.
         rem_d = fits ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
         quo_d = {quo_q[WIDTH-3:0], fits};
         cnt_d = cnt_q - CntW'(1);
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         rem_q <= '0;
         dsr_q <= '0;
         quo_q <= '0;
         cnt_q <= '0;
      end else begin
         rem_q <= rem_d;
         dsr_q <= dsr_d;
         quo_q <= quo_d;
         cnt_q <= cnt_d;
      end
   end

   // Final bit is presented combinationally so the caller can commit on the last step.
   assign done     = (cnt_q == CntW'(1));
   assign quotient = {quo_q, fits};

endmodule

// File: rtl/pwl_chaos_rng.sv
// Chaotic-map RNG: skew tent (divider based), tent and Bernoulli shift on a Q0.WIDTH state,
// with a guard that kicks the orbit off fixed points and zero.
module pwl_chaos_rng
   import pwl_rng_pkg::*;
#(
   parameter int unsigned WIDTH        = 16,
   parameter int unsigned OUT_W        = 8,
   parameter logic [31:0] DEFAULT_SEED = 32'(DefaultSeed),
   parameter logic [31:0] PERTURB      = 32'(DefaultPerturb)
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             start_i,
   input  logic             seed_load_i,
   input  logic [WIDTH-1:0] seed_i,
   input  logic [WIDTH-1:0] p_i,
   input  logic [1:0]       mode_i,
   output logic             ready_o,
   output logic             valid_o,
   output logic [OUT_W-1:0] rand_o
);

   localparam logic [WIDTH-1:0] SeedW    = DEFAULT_SEED[WIDTH-1:0];
   localparam logic [WIDTH-1:0] PerturbW = PERTURB[WIDTH-1:0];
   localparam logic [WIDTH-1:0] Half     = {1'b1, {(WIDTH-1){1'b0}}};

   state_e           state_q, state_d;
   logic [WIDTH-1:0] x_q, x_d;
   logic [OUT_W-1:0] rand_q, rand_d;
   logic [WIDTH-1:0] x_new, p_eff;
   logic             commit;
   logic             div_start, div_done;
   logic [WIDTH-1:0] div_dividend, div_divisor, div_quotient;

   function automatic logic [WIDTH-1:0] guard(input logic [WIDTH-1:0] nxt,
                                              input logic [WIDTH-1:0] old);
      return (nxt == '0 || nxt == old) ? (nxt ^ PerturbW) : nxt;
   endfunction

   pwl_divider #(
      .WIDTH(WIDTH)
   ) u_div (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .start   (div_start),
      .dividend(div_dividend),
      .divisor (div_divisor),
      .done    (div_done),
      .quotient(div_quotient)
   );

   always_comb begin
      state_d      = state_q;
      x_d          = x_q;
      x_new        = '0;
      commit       = 1'b0;
      div_start    = 1'b0;
      div_dividend = '0;
      div_divisor  = '0;
      p_eff        = (p_i == '0) ? Half : p_i;
      unique case (state_q)
         StIdle: begin
            if (seed_load_i) begin
               x_d = (seed_i == '0) ? SeedW : seed_i;
            end else if (start_i) begin
               unique case (mode_i)
                  ModeTent: begin
                     x_new  = x_q[WIDTH-1] ? {~x_q[WIDTH-2:0], 1'b0} : {x_q[WIDTH-2:0], 1'b0};
                     commit = 1'b1;
                  end
                  ModeShift: begin
                     x_new  = {x_q[WIDTH-2:0], 1'b0};
                     commit = 1'b1;
                  end
                  default: begin
                     // Right branch: ~x is 2^W-1-x and -p is 2^W-p, keeping dividend < divisor.
                     div_start = 1'b1;
                     if (x_q < p_eff) begin
                        div_dividend = x_q;
                        div_divisor  = p_eff;
                     end else begin
                        div_dividend = ~x_q;
                        div_divisor  = -p_eff;
                     end
                     state_d = StCalc;
                  end
               endcase
            end
         end
         StCalc: begin
            x_new = div_quotient;
            if (div_done) begin
               commit = 1'b1;
            end
         end
         StDone: state_d = StIdle;
         default: state_d = StIdle;
      endcase
      if (commit) begin
         x_d     = guard(x_new, x_q);
         state_d = StDone;
      end
      rand_d = x_d[WIDTH-1 -: OUT_W];
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= StIdle;
         x_q     <= SeedW;
         rand_q  <= SeedW[WIDTH-1 -: OUT_W];
      end else begin
         state_q <= state_d;
         x_q     <= x_d;
         rand_q  <= rand_d;
      end
   end

   assign ready_o = (state_q == StIdle);
   assign valid_o = (state_q == StDone);
   assign rand_o  = rand_q;

endmodule
